// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_t    : frame parser states
//   HDR_BYTES  : bytes per little-endian header field / data word
//   WSTRB_FULL : byte-strobe pattern for a full-word write
package imem_loader_pkg;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned CNT_W      = $clog2(HDR_BYTES);
    localparam int unsigned STRB_W     = 4;
    localparam logic [STRB_W-1:0] WSTRB_FULL = 4'hF;

    typedef enum logic [2:0] {
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE
    } state_t;

endpackage

// File: rtl/le_word_assembler.sv
// Little-endian word assembler: collects four bytes into a 32-bit word.
// Reused for the start address, the word count and every data word.
//   clk, rst         : clock, async active-high reset
//   i_clear          : return the byte counter and shift register to zero
//   i_accept         : i_byte is consumed this cycle
//   i_byte           : incoming stream byte
//   o_word_c         : word as it would look with i_byte as its top byte
//   o_word_valid_c   : this accept completes a word (o_word_c is the word)
//   o_cnt_next_c     : byte count after this cycle
module le_word_assembler
    import imem_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_accept,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [WORD_W-1:0] o_word_c,
    output logic              o_word_valid_c,
    output logic [CNT_W-1:0]  o_cnt_next_c
);

    localparam int unsigned SHIFT_W = WORD_W - BYTE_W;

    logic [CNT_W-1:0]   r_cnt;
    logic [SHIFT_W-1:0] r_shift;

    // New byte enters at the top; after four bytes byte k sits at [8k+7:8k].
    always_comb begin
        o_word_c       = {i_byte, r_shift};
        o_word_valid_c = i_accept && (r_cnt == CNT_W'(HDR_BYTES - 1));
        o_cnt_next_c   = r_cnt;
        if (i_clear) begin
            o_cnt_next_c = '0;
        end else if (i_accept) begin
            o_cnt_next_c = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else begin
            r_cnt <= o_cnt_next_c;
            if (i_clear) begin
                r_shift <= '0;
            end else if (i_accept) begin
                r_shift <= o_word_c[WORD_W-1:BYTE_W];
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream
// (address, word count, data words, checksum), writes each assembled
// word to the memory write port and reports per-frame status.
//   clk, rst        : clock, async active-high reset
//   in_data/valid   : stream byte and its valid
//   in_ready        : loader accepts a byte this cycle
//   imem_ena/wea    : write enable and byte strobes
//   imem_addra/dina : word address and write data
//   busy            : a frame is in progress
//   done            : one-cycle end-of-frame pulse
//   error           : status of the last completed frame
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = 14
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_ena,
    output logic [STRB_W-1:0] imem_wea,
    output logic [AW-1:0]     imem_addra,
    output logic [WORD_W-1:0] imem_dina,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned CMP_W = 34;

    state_t              r_state,     w_state_n;
    logic [WORD_W-1:0]   r_addr,      w_addr_n;
    logic [WORD_W-1:0]   r_words_left, w_words_left_n;
    logic [AW-1:0]       r_ptr,       w_ptr_n;
    logic [BYTE_W-1:0]   r_sum,       w_sum_n;
    logic                r_bad,       w_bad_n;
    logic                r_in_ready,  w_in_ready_n;
    logic                r_ena,       w_ena_n;
    logic [STRB_W-1:0]   r_wea,       w_wea_n;
    logic [AW-1:0]       r_addra,     w_addra_n;
    logic [WORD_W-1:0]   r_dina,      w_dina_n;
    logic                r_busy,      w_busy_n;
    logic                r_done,      w_done_n;
    logic                r_error,     w_error_n;

    logic                w_accept;
    logic                w_asm_accept;
    logic                w_asm_clear;
    logic [WORD_W-1:0]   w_word_c;
    logic                w_word_valid_c;
    logic [CNT_W-1:0]    w_cnt_next_c;
    logic [CMP_W-1:0]    w_idx34;
    logic [CMP_W-1:0]    w_end34;
    logic                w_hdr_bad;
    logic                w_csum_bad;

    assign in_ready   = r_in_ready;
    assign imem_ena   = r_ena;
    assign imem_wea   = r_wea;
    assign imem_addra = r_addra;
    assign imem_dina  = r_dina;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

    // Header fields and data words all share one byte assembler.
    assign w_accept     = in_valid && r_in_ready;
    assign w_asm_accept = w_accept &&
                          ((r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_DATA));
    assign w_asm_clear  = (r_state == S_DONE);

    le_word_assembler u_asm (
        .clk            (clk),
        .rst            (rst),
        .i_clear        (w_asm_clear),
        .i_accept       (w_asm_accept),
        .i_byte         (in_data),
        .o_word_c       (w_word_c),
        .o_word_valid_c (w_word_valid_c),
        .o_cnt_next_c   (w_cnt_next_c)
    );

    // Range check evaluated as the last length byte arrives; 34 bits so
    // word index + count cannot overflow.
    assign w_idx34   = CMP_W'(r_addr[WORD_W-1:2]);
    assign w_end34   = w_idx34 + CMP_W'(w_word_c);
    assign w_hdr_bad = (r_addr[1:0] != 2'b00) ||
                       (w_end34 > CMP_W'(DEPTH)) ||
                       ((w_idx34 >= CMP_W'(DEPTH)) && (w_word_c != '0));
    assign w_csum_bad = (in_data != r_sum);

    // Next-state and registered-output logic.
    always_comb begin
        w_state_n      = r_state;
        w_addr_n       = r_addr;
        w_words_left_n = r_words_left;
        w_ptr_n        = r_ptr;
        w_sum_n        = r_sum;
        w_bad_n        = r_bad;
        w_ena_n        = 1'b0;
        w_wea_n        = '0;
        w_addra_n      = r_addra;
        w_dina_n       = r_dina;
        w_done_n       = 1'b0;
        w_error_n      = r_error;

        if (w_asm_accept) begin
            w_sum_n = r_sum + in_data;
        end

        case (r_state)
            S_ADDR: begin
                if (w_word_valid_c) begin
                    w_addr_n  = w_word_c;
                    w_state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (w_word_valid_c) begin
                    w_bad_n        = r_bad | w_hdr_bad;
                    w_words_left_n = w_word_c;
                    w_ptr_n        = r_addr[AW+1:2];
                    w_state_n      = (w_word_c == '0) ? S_CSUM : S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_valid_c) begin
                    // Bad-header frames are drained but never written.
                    if (!r_bad) begin
                        w_ena_n   = 1'b1;
                        w_wea_n   = WSTRB_FULL;
                        w_addra_n = r_ptr;
                        w_dina_n  = w_word_c;
                    end
                    w_ptr_n        = r_ptr + AW'(1);
                    w_words_left_n = r_words_left - WORD_W'(1);
                    if (r_words_left == WORD_W'(1)) begin
                        w_state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_bad_n   = r_bad | w_csum_bad;
                    w_done_n  = 1'b1;
                    w_error_n = r_bad | w_csum_bad;
                    w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_bad_n   = 1'b0;
                w_sum_n   = '0;
                w_state_n = S_ADDR;
            end
            default: begin
                w_state_n = S_ADDR;
            end
        endcase

        w_in_ready_n = (w_state_n != S_DONE);
        w_busy_n     = !((w_state_n == S_ADDR) && (w_cnt_next_c == '0));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ADDR;
            r_addr       <= '0;
            r_words_left <= '0;
            r_ptr        <= '0;
            r_sum        <= '0;
            r_bad        <= 1'b0;
            r_in_ready   <= 1'b0;
            r_ena        <= 1'b0;
            r_wea        <= '0;
            r_addra      <= '0;
            r_dina       <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_addr       <= w_addr_n;
            r_words_left <= w_words_left_n;
            r_ptr        <= w_ptr_n;
            r_sum        <= w_sum_n;
            r_bad        <= w_bad_n;
            r_in_ready   <= w_in_ready_n;
            r_ena        <= w_ena_n;
            r_wea        <= w_wea_n;
            r_addra      <= w_addra_n;
            r_dina       <= w_dina_n;
            r_busy       <= w_busy_n;
            r_done       <= w_done_n;
            r_error      <= w_error_n;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write/status scoreboard.
module tb_imem_loader;

    localparam int unsigned DEPTH = 16384;
    localparam int unsigned AW    = 14;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_ena;
    logic [3:0]    imem_wea;
    logic [AW-1:0] imem_addra;
    logic [31:0]   imem_dina;
    logic          busy;
    logic          done;
    logic          error;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;
    wr_t  exp_wr[$];
    logic exp_err[$];
    logic [7:0] data_q[$];
    wr_t  mon_wr;
    logic mon_err;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_ena   (imem_ena),
        .imem_wea   (imem_wea),
        .imem_addra (imem_addra),
        .imem_dina  (imem_dina),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard monitor: sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_ena) begin
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL unexpected_write: observed addr %h data %h expected no write",
                           imem_addra, imem_dina);
                end else begin
                    mon_wr = exp_wr.pop_front();
                    check("wr_addr", 32'(imem_addra), 32'(mon_wr.addr));
                    check("wr_data", imem_dina, mon_wr.data);
                    check("wr_strb", 32'(imem_wea), 32'h0000000F);
                end
            end
            if (done) begin
                n_done++;
                if (exp_err.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL unexpected_done: observed done=1 expected no done");
                end else begin
                    mon_err = exp_err.pop_front();
                    check("done_error", 32'(error), 32'(mon_err));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("byte_accept", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Builds a frame from a, n and data_q, predicts writes and status, sends it.
    task automatic send_frame(input logic [31:0] a, input logic [31:0] n,
                              input logic [7:0] cdelta, input int gap_max);
        logic [7:0] bytes[$];
        logic [7:0] sum = 8'h00;
        longint unsigned widx = longint'(a >> 2);
        logic bad;
        logic err;
        int done_before;
        wr_t w;
        bad = (a[1:0] != 2'b00) || (widx + longint'(n) > longint'(DEPTH)) ||
              ((widx >= longint'(DEPTH)) && (n != 0));
        err = bad || (cdelta != 8'h00);
        for (int i = 0; i < 4; i++) bytes.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) bytes.push_back(n[8*i +: 8]);
        for (int i = 0; i < int'(n) * 4; i++) bytes.push_back(data_q[i]);
        foreach (bytes[i]) sum = sum + bytes[i];
        bytes.push_back(sum + cdelta);
        if (!bad) begin
            for (int k = 0; k < int'(n); k++) begin
                w.addr = AW'(widx + longint'(k));
                w.data = {data_q[4*k+3], data_q[4*k+2], data_q[4*k+1], data_q[4*k]};
                exp_wr.push_back(w);
            end
        end
        exp_err.push_back(err);
        done_before = n_done;
        foreach (bytes[i]) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) @(posedge clk);
                #1;
            end
            send_byte(bytes[i]);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("error_at_done", 32'(error), 32'(err));
        check("ready_in_done", 32'(in_ready), 32'd0);
        check("busy_in_done", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check("done_cleared", 32'(done), 32'd0);
        check("error_held", 32'(error), 32'(err));
        check("busy_idle", 32'(busy), 32'd0);
        check("ready_idle", 32'(in_ready), 32'd1);
        check("writes_drained", 32'(exp_wr.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(done_before + 1));
    endtask

    initial begin
        logic [7:0] hdr[$];
        logic [31:0] ra;
        logic [31:0] rn;

        // Reset values.
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_ena", 32'(imem_ena), 32'd0);
        check("rst_wea", 32'(imem_wea), 32'd0);
        check("rst_addra", 32'(imem_addra), 32'd0);
        check("rst_dina", imem_dina, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("ready_first_cycle", 32'(in_ready), 32'd0);

        // Two-word frame, correct checksum, then off by one.
        data_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        send_frame(32'h100, 32'd2, 8'h00, 0);
        send_frame(32'h100, 32'd2, 8'h01, 2);

        // Misaligned start: drained, no writes, error.
        data_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        send_frame(32'h102, 32'd1, 8'h00, 0);

        // Top-of-memory boundary.
        data_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(32'hFFFC, 32'd1, 8'h00, 0);
        send_frame(32'hFFFC, 32'd2, 8'h00, 1);

        // Empty frames.
        send_frame(32'h0, 32'd0, 8'h00, 0);
        send_frame(32'h10000, 32'd0, 8'h00, 0);

        // Reset after two data bytes, then a fresh frame.
        hdr = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'hC1, 8'hC2};
        foreach (hdr[i]) send_byte(hdr[i]);
        check("busy_mid_frame", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_ena", 32'(imem_ena), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        data_q = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
        send_frame(32'h200, 32'd2, 8'h00, 0);

        // Random aligned frames with idle gaps.
        for (int f = 0; f < 3; f++) begin
            rn = 32'($urandom_range(1, 5));
            ra = {16'h0, 14'($urandom_range(0, 16000)), 2'b00};
            data_q.delete();
            for (int i = 0; i < int'(rn) * 4; i++) data_q.push_back(8'($urandom));
            send_frame(ra, rn, 8'h00, 3);
        end

        repeat (3) @(posedge clk);
        #1;
        check("final_wr_queue", 32'(exp_wr.size()), 32'd0);
        check("final_err_queue", 32'(exp_err.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side front end for the instruction memory. It drives the memory's byte-enabled write port (enable, 4-bit byte-write strobe, 14-bit word address, 32-bit data).
- It consumes a framed byte stream, normally from the UART receiver, and assembles little-endian 32-bit words.
- It range-checks the frame header, issues one full-word write per assembled word, and validates a trailing checksum.
- It reports busy, done and error status to the boot controller.

Parameters:
- DEPTH, 16384: number of 32-bit words in the target memory.
- AW, 14: word-address width; must satisfy 2**AW == DEPTH.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready
- imem_ena  out  1  write enable to the memory's write port
- imem_wea  out  4  byte strobes; always 4'hF when imem_ena=1, otherwise 4'h0
- imem_addra  out  AW  word address
- imem_dina  out  32  write data
- busy  out  1  a frame is in progress (any state except S_ADDR with byte count 0)
- done  out  1  one-cycle pulse at end of frame
- error  out  1  status of the last completed frame; valid while done=1 and held until the next done

Behaviour:
- Frame format, all fields little-endian:
  - 4 bytes: start byte address A.
  - 4 bytes: word count N.
  - 4*N bytes: data.
  - 1 byte: checksum C. C must equal the mod-256 sum of every preceding byte of the frame (header and data).
- Reset values: in_ready=0, imem_ena=0, imem_wea=0, imem_addra=0, imem_dina=0, busy=0, done=0, error=0. Internal state: S_ADDR, byte count 0, sum 0.
- in_ready=1 in S_ADDR, S_LEN, S_DATA and S_CSUM; in_ready=0 in S_DONE. Reset is asynchronous, so in_ready is 0 for the first cycle after reset deasserts.
- State S_ADDR: shift 4 bytes into A.
  - After the 4th byte, go to S_LEN.
- State S_LEN: shift 4 bytes into N.
  - After the 4th byte, evaluate the header.
  - Header is bad if A[1:0]!=0, or (A>>2)+N > DEPTH (compare at ≥34-bit width, no overflow), or A>>2 >= DEPTH with N>0.
  - Bad header sets the internal flag bad=1. Reached with bad=1, S_DATA still consumes all 4*N bytes but suppresses every write.
  - N==0 goes directly to S_CSUM; otherwise go to S_DATA.
  - Word pointer is set to A[AW+1:2].
- State S_DATA: byte k of a word goes to bits [8k+7:8k].
  - Write latency: the cycle after the 4th byte of a word is accepted, imem_ena=1, imem_wea=4'hF, imem_addra=pointer and imem_dina=word, for exactly one cycle.
  - The pointer then increments; because of the range check it never wraps.
  - Back-to-back valid bytes are accepted with no stalls; a write pulse may coincide with acceptance of the next word's first byte.
  - After the last data byte, go to S_CSUM.
- State S_CSUM: accept one byte and compare it with the running sum.
  - A mismatch sets the internal flag bad=1.
  - Go to S_DONE.
- State S_DONE: assert done=1 and error=bad for one cycle.
  - Clear bad, the sum and the byte count, then return to S_ADDR.
- Running sum: 8-bit, wraps modulo 256, includes every accepted byte from the first address byte onward.
- The last data word's write pulse occurs in the checksum-accept cycle or earlier. Writes are never retracted on a checksum error; software reloads the frame.
- Reset mid-frame: all state returns to reset values immediately and any pending write is dropped. The next byte is treated as address byte 0.
- in_valid=0 at any point: state holds indefinitely (no timeout).

Decomposition:
- Package imem_loader_pkg:
  - state enum {S_ADDR, S_LEN, S_DATA, S_CSUM, S_DONE}
  - HDR_BYTES=4
  - WSTRB_FULL=4'hF
- Sub-module le_word_assembler: 2-bit byte counter plus 32-bit shift register with a word_valid pulse; it is reused for A, N and data words.
- Range check and checksum stay in the top level.

Test Plan:
- Frame A=0x100, N=2, data 11 22 33 44 55 66 77 88, correct C -> two writes: addra=0x040, dina=0x44332211; addra=0x041, dina=0x88776655; wea=4'hF; done with error=0.
- Same frame with C off by one -> same two writes occur; done pulse with error=1.
- A=0x102 (misaligned), N=1 -> no imem_ena pulse; all 9 following bytes consumed; error=1.
- A=0xFFFC, N=1 -> write to addra=0x3FFF, error=0. A=0xFFFC, N=2 -> no writes, error=1.
- N=0, A=0, C=0x00 -> no writes; done with error=0 one cycle after C is accepted.
- Assert rst after 2 data bytes, then send a fresh valid frame -> no stale write occurs; the fresh frame loads correctly with error=0.
